// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin valid/ready arbiter sharing one 16-bit alu between two requesters.
// One operation in flight: IDLE accepts, EXEC computes from registered operands, RESP holds the result.
module alu (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [2:0]  op,
  input  logic        sel,
  output logic [15:0] out,
  output logic        carry
);
  logic [15:0] a, b;
  logic [16:0] sum;
  assign a = sel ? in2 : in1;
  assign b = sel ? in1 : in2;
  assign sum = {1'b0, a} + {1'b0, b};
  // carry is only meaningful for add; callers must mask it for other ops
  assign carry = sum[16];
  always_comb begin
    out = op == 3'b001 ? sum[15:0] :
          op == 3'b010 ? a - b :
          op == 3'b011 ? a & b :
          op == 3'b100 ? a | b :
          op == 3'b101 ? a ^ b :
          op == 3'b110 ? (|b[15:4] ? 16'h0 : a << b[3:0]) :
          op == 3'b111 ? (|b[15:4] ? 16'h0 : a >> b[3:0]) : 16'h0;
  end
endmodule

module alu_arbiter #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_in1,
  input  logic [15:0] req0_in2,
  input  logic [2:0]  req0_op,
  input  logic        req0_sel,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_in1,
  input  logic [15:0] req1_in2,
  input  logic [2:0]  req1_op,
  input  logic        req1_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_out,
  output logic        rsp_sign,
  output logic        rsp_zero,
  output logic        rsp_carry,
  output logic        rsp_err,
  output logic [15:0] ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic prio, gnt, take;
  logic [15:0] in1_q, in2_q, alu_out;
  logic [2:0] op_q;
  logic sel_q, id_q, alu_carry;
  assign gnt = (req0_valid & req1_valid) ? prio : req1_valid;
  assign req0_ready = state == IDLE & req0_valid & ~gnt;
  assign req1_ready = state == IDLE & req1_valid & gnt;
  assign take = req0_ready | req1_ready;
  assign rsp_valid = state == RESP;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (take ? EXEC : IDLE) :
               state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  alu u_alu (.in1(in1_q), .in2(in2_q), .op(op_q), .sel(sel_q), .out(alu_out), .carry(alu_carry));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in1_q <= '0;
      in2_q <= '0;
      op_q <= '0;
      sel_q <= 1'b0;
      id_q <= 1'b0;
    end else if (take) begin
      in1_q <= gnt ? req1_in1 : req0_in1;
      in2_q <= gnt ? req1_in2 : req0_in2;
      op_q <= gnt ? req1_op : req0_op;
      sel_q <= gnt ? req1_sel : req0_sel;
      id_q <= gnt;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id <= 1'b0;
      rsp_out <= '0;
      rsp_sign <= 1'b0;
      rsp_zero <= 1'b0;
      rsp_carry <= 1'b0;
      rsp_err <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id <= id_q;
      rsp_out <= alu_out;
      rsp_sign <= alu_out[15];
      rsp_zero <= alu_out == 16'h0;
      rsp_carry <= op_q == 3'b001 & alu_carry;
      rsp_err <= op_q == 3'b000;
    end
  end
  // the requester just served loses priority on the response handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_done <= '0;
      prio <= PRIO_INIT;
    end else if (rsp_valid & rsp_ready) begin
      ops_done <= ops_done + 16'd1;
      prio <= ~rsp_id;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter; expected responses are queued at grant
// and compared when the DUT presents them.
module tb_alu_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 0, req1_valid = 0, req0_sel = 0, req1_sel = 0, rsp_ready = 0;
  logic [15:0] req0_in1 = 0, req0_in2 = 0, req1_in1 = 0, req1_in2 = 0;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sign, rsp_zero, rsp_carry, rsp_err;
  logic [15:0] rsp_out, ops_done;
  int checks = 0, errors = 0, exp_done = 0;

  typedef struct packed {
    logic id;
    logic [15:0] out;
    logic sign, zero, carry, err;
  } rsp_t;
  rsp_t q[$];

  always #5 clk = ~clk;

  alu_arbiter #(.PRIO_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req0_op(req0_op), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1), .req1_in2(req1_in2),
    .req1_op(req1_op), .req1_sel(req1_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
    .rsp_sign(rsp_sign), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .ops_done(ops_done)
  );

  // reference: 001 add, 010 sub, 011 and, 100 or, 101 xor, 110 shl, 111 shr, 000 illegal
  function automatic rsp_t mk(input logic id, input logic [15:0] x, input logic [15:0] y,
                              input logic [2:0] op, input logic sel);
    logic [15:0] a, b, r;
    logic [16:0] s;
    rsp_t e;
    a = sel ? y : x;
    b = sel ? x : y;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      3'd1: r = s[15:0];
      3'd2: r = a - b;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = (b >= 16) ? 16'h0 : a << b;
      3'd7: r = (b >= 16) ? 16'h0 : a >> b;
      default: r = 16'h0;
    endcase
    e.id = id;
    e.out = r;
    e.sign = r[15];
    e.zero = (r == 16'h0);
    e.carry = (op == 3'd1) & s[16];
    e.err = (op == 3'd0);
    return e;
  endfunction

  function automatic rsp_t got();
    return {rsp_id, rsp_out, rsp_sign, rsp_zero, rsp_carry, rsp_err};
  endfunction

  function automatic logic rdy(input logic id);
    return id ? req1_ready : req0_ready;
  endfunction

  task automatic drive(input logic id, input logic v, input logic [15:0] x, input logic [15:0] y,
                       input logic [2:0] op, input logic sel);
    if (id) begin
      req1_valid = v; req1_in1 = x; req1_in2 = y; req1_op = op; req1_sel = sel;
    end else begin
      req0_valid = v; req0_in1 = x; req0_in2 = y; req0_op = op; req0_sel = sel;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    q.delete();
    exp_done = 0;
  endtask

  task automatic send(input logic id, input logic [15:0] x, input logic [15:0] y,
                      input logic [2:0] op, input logic sel);
    int n = 0;
    @(posedge clk); #1 drive(id, 1'b1, x, y, op, sel);
    @(negedge clk);
    while (!rdy(id) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rdy(id)) begin
      errors++;
      $display("FAIL send_ready id=%0d: ready=0 after 20 cycles, required 1", id);
    end else q.push_back(mk(id, x, y, op, sel));
    @(posedge clk); #1 drive(id, 1'b0, x, y, op, sel);
  endtask

  task automatic recv(input string name, input int lat, output rsp_t r);
    int n = 0;
    rsp_t e;
    r = '0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL %s_timeout: rsp_valid=0 after 20 cycles, required 1", name);
    end else if (q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: response %h with empty scoreboard", name, got());
    end else begin
      r = got();
      e = q.pop_front();
      if (r !== e) begin
        errors++;
        $display("FAIL %s_rsp: got id/out/s/z/c/e=%h, required %h", name, r, e);
      end
      if (lat >= 0) begin
        checks++;
        if (n != lat) begin
          errors++;
          $display("FAIL %s_latency: got %0d, required %0d", name, n, lat);
        end
      end
    end
    @(posedge clk); #1 exp_done++;
    checks++;
    if (ops_done !== 16'(exp_done)) begin
      errors++;
      $display("FAIL %s_ops_done: got %0d, required %0d", name, ops_done, exp_done);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, req0_ready, req1_ready, got(), ops_done} !== '0) begin
      errors++;
      $display("FAIL reset_in: got v=%b r0=%b r1=%b rsp=%h done=%h, required all 0",
               rsp_valid, req0_ready, req1_ready, got(), ops_done);
    end
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, req0_ready, req1_ready, got(), ops_done} !== '0) begin
      errors++;
      $display("FAIL reset_out: got v=%b rsp=%h done=%h, required all 0", rsp_valid, got(), ops_done);
    end
  endtask

  task automatic test_single_add();
    rsp_t r;
    rsp_ready = 1;
    send(0, 16'hFFFF, 16'h0001, 3'd1, 0);
    recv("single_add", 1, r);
    checks++;
    if (r !== {1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_add_lit: got %h, required id0 out0 sign0 zero1 carry1 err0", r);
    end
  endtask

  task automatic test_contention();
    int grants = 0, rsps = 0, last = 0;
    logic gid;
    rsp_t r, e;
    apply_reset();
    rsp_ready = 1;
    @(posedge clk); #1
    drive(0, 1'b1, 16'd10, 16'd3, 3'd1, 0);
    drive(1, 1'b1, 16'd10, 16'd3, 3'd2, 0);
    for (int i = 0; i < 40 && rsps < 4; i++) begin
      @(negedge clk);
      if (grants == 4) begin
        req0_valid = 0;
        req1_valid = 0;
      end
      if (req0_ready | req1_ready) begin
        gid = req1_ready;
        checks++;
        if (gid !== 1'(grants % 2) || (req0_ready & req1_ready)) begin
          errors++;
          $display("FAIL contention_grant #%0d: got r0=%b r1=%b, required id %0d", grants,
                   req0_ready, req1_ready, grants % 2);
        end
        q.push_back(gid ? mk(1, req1_in1, req1_in2, req1_op, req1_sel)
                        : mk(0, req0_in1, req0_in2, req0_op, req0_sel));
        grants++;
      end
      if (rsp_valid) begin
        r = got();
        e = q.size() > 0 ? q.pop_front() : '0;
        checks++;
        if (r !== e || r.id !== 1'(rsps % 2)) begin
          errors++;
          $display("FAIL contention_rsp #%0d: got %h, required %h (id %0d)", rsps, r, e, rsps % 2);
        end
        if (rsps > 0) begin
          checks++;
          if (i - last != 3) begin
            errors++;
            $display("FAIL contention_spacing: got %0d cycles, required 3", i - last);
          end
        end
        last = i;
        rsps++;
      end
    end
    checks++;
    if (rsps != 4) begin
      errors++;
      $display("FAIL contention_count: got %0d responses, required 4", rsps);
    end
    @(posedge clk); #1 exp_done = 4;
    checks++;
    if (ops_done !== 16'd4) begin
      errors++;
      $display("FAIL contention_ops_done: got %0d, required 4", ops_done);
    end
  endtask

  task automatic test_back_pressure();
    rsp_t r;
    rsp_ready = 0;
    send(1, 16'd3, 16'd5, 3'd2, 0);
    drive(0, 1'b1, 16'h0011, 16'h0022, 3'd4, 0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1 || rsp_out !== 16'hFFFE || rsp_sign !== 1 || rsp_carry !== 0 ||
          rsp_id !== 1 || req0_ready !== 0) begin
        errors++;
        $display("FAIL backpressure_hold c%0d: got v=%b out=%h s=%b c=%b id=%b r0=%b, required 1 fffe 1 0 1 0",
                 k, rsp_valid, rsp_out, rsp_sign, rsp_carry, rsp_id, req0_ready);
      end
    end
    @(posedge clk); #1 rsp_ready = 1;
    recv("backpressure", 0, r);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1) begin
      errors++;
      $display("FAIL backpressure_regrant: got req0_ready=%b, required 1", req0_ready);
    end else q.push_back(mk(0, 16'h0011, 16'h0022, 3'd4, 0));
    @(posedge clk); #1 req0_valid = 0;
    recv("backpressure_req0", 1, r);
  endtask

  task automatic test_carry_isolation();
    rsp_t r;
    send(0, 16'h8000, 16'h8000, 3'd1, 0);
    recv("carry_add", 1, r);
    checks++;
    if (r.carry !== 1 || r.out !== 16'h0) begin
      errors++;
      $display("FAIL carry_add_lit: got carry=%b out=%h, required 1 0000", r.carry, r.out);
    end
    send(0, 16'h00F0, 16'h0F00, 3'd3, 0);
    recv("carry_and", 1, r);
    checks++;
    if (r.out !== 16'h0 || r.zero !== 1 || r.carry !== 0) begin
      errors++;
      $display("FAIL carry_and_lit: got out=%h zero=%b carry=%b, required 0000 1 0", r.out, r.zero, r.carry);
    end
  endtask

  task automatic test_illegal_shift();
    rsp_t r;
    send(0, 16'h1234, 16'h5678, 3'd0, 0);
    recv("illegal", 1, r);
    checks++;
    if (r.err !== 1 || r.out !== 16'h0 || r.zero !== 1) begin
      errors++;
      $display("FAIL illegal_lit: got err=%b out=%h zero=%b, required 1 0000 1", r.err, r.out, r.zero);
    end
    send(0, 16'd1, 16'd20, 3'd6, 0);
    recv("shl20", 1, r);
    checks++;
    if (r.out !== 16'h0 || r.err !== 0) begin
      errors++;
      $display("FAIL shl20_lit: got out=%h err=%b, required 0000 0", r.out, r.err);
    end
    send(0, 16'd4, 16'h8000, 3'd7, 1);
    recv("shr_swap", 1, r);
    checks++;
    if (r.out !== 16'h0800) begin
      errors++;
      $display("FAIL shr_swap_lit: got out=%h, required 0800", r.out);
    end
  endtask

  task automatic test_async_reset();
    rsp_t r;
    send(0, 16'd5, 16'd6, 3'd1, 0);
    #2 rst_n = 0;
    #1;
    checks++;
    if (rsp_valid !== 0 || ops_done !== 16'h0 || got() !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%b done=%h rsp=%h, required 0 0 0", rsp_valid, ops_done, got());
    end
    q.delete();
    exp_done = 0;
    @(posedge clk); #1 rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 0) begin
        errors++;
        $display("FAIL async_reset_stale c%0d: got rsp_valid=1, required 0", k);
      end
    end
    send(0, 16'd7, 16'd9, 3'd1, 0);
    recv("after_reset", 1, r);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_contention();
    test_back_pressure();
    test_carry_isolation();
    test_illegal_shift();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
